// File: rtl/lc3b_control_fsm_pkg.sv
// Shared types and constants for the LC-3b multicycle controller.
//   lc3b_opcode         : IR[15:12] encodings
//   lc3b_aluop          : ALU function select
//   lc3b_*mux_sel       : datapath mux selects driven by the controller
//   ST_*                : controller state encodings
//   is_wait_state()     : states that hold a memory request until mem_resp
package lc3b_control_fsm_pkg;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   typedef enum logic [2:0] {
      alu_add  = 3'd0,
      alu_and  = 3'd1,
      alu_not  = 3'd2,
      alu_pass = 3'd3,
      alu_sll  = 3'd4,
      alu_srl  = 3'd5,
      alu_sra  = 3'd6
   } lc3b_aluop;

   typedef enum logic [1:0] {
      pcmux_pc_plus2 = 2'd0,
      pcmux_pc_off9  = 2'd1,
      pcmux_sr1      = 2'd2,
      pcmux_mdr      = 2'd3
   } lc3b_pcmux_sel;

   typedef enum logic [1:0] {
      marmux_alu      = 2'd0,
      marmux_pc       = 2'd1,
      marmux_mdr      = 2'd2,
      marmux_trapvect = 2'd3
   } lc3b_marmux_sel;

   typedef enum logic [1:0] {
      alumux_sr2  = 2'd0,
      alumux_off6 = 2'd1,
      alumux_imm5 = 2'd2,
      alumux_imm4 = 2'd3
   } lc3b_alumux_sel;

   typedef enum logic [2:0] {
      rfmux_alu      = 3'd0,
      rfmux_mdr      = 3'd1,
      rfmux_pc_off9  = 3'd2,
      rfmux_pc       = 3'd3,
      rfmux_mdr_byte = 3'd4
   } lc3b_regfilemux_sel;

   localparam logic [4:0] ST_FETCH1    = 5'd0;
   localparam logic [4:0] ST_FETCH2    = 5'd1;
   localparam logic [4:0] ST_FETCH3    = 5'd2;
   localparam logic [4:0] ST_DECODE    = 5'd3;
   localparam logic [4:0] ST_ADD       = 5'd4;
   localparam logic [4:0] ST_AND       = 5'd5;
   localparam logic [4:0] ST_NOT       = 5'd6;
   localparam logic [4:0] ST_SHF       = 5'd7;
   localparam logic [4:0] ST_BR        = 5'd8;
   localparam logic [4:0] ST_BR_TAKEN  = 5'd9;
   localparam logic [4:0] ST_JMP       = 5'd10;
   localparam logic [4:0] ST_JSR_LINK  = 5'd11;
   localparam logic [4:0] ST_JSR_JUMP  = 5'd12;
   localparam logic [4:0] ST_LEA       = 5'd13;
   localparam logic [4:0] ST_CALC_ADDR = 5'd14;
   localparam logic [4:0] ST_IND_RD    = 5'd15;
   localparam logic [4:0] ST_IND_MAR   = 5'd16;
   localparam logic [4:0] ST_LD_RD     = 5'd17;
   localparam logic [4:0] ST_LDR_WB    = 5'd18;
   localparam logic [4:0] ST_LDB_WB    = 5'd19;
   localparam logic [4:0] ST_STR_MDR   = 5'd20;
   localparam logic [4:0] ST_ST_WR     = 5'd21;
   localparam logic [4:0] ST_TRAP_LINK = 5'd22;
   localparam logic [4:0] ST_TRAP_MAR  = 5'd23;
   localparam logic [4:0] ST_TRAP_RD   = 5'd24;
   localparam logic [4:0] ST_TRAP_PC   = 5'd25;

   function automatic logic is_wait_state(input logic [4:0] st);
      return (st == ST_FETCH2) || (st == ST_IND_RD) || (st == ST_LD_RD) ||
             (st == ST_ST_WR)  || (st == ST_TRAP_RD);
   endfunction

endpackage

// File: rtl/lc3b_mem_watchdog.sv
// Memory-wait watchdog: counts wait cycles without a response and flags
// the cycle in which the limit is reached.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : controller is entering a wait state this edge
//   waiting    : controller is currently in a wait state
//   mem_resp   : memory completion
//   timeout    : limit reached with no response (combinational)
module lc3b_mem_watchdog #(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic waiting,
   input  logic mem_resp,
   output logic timeout
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] LIMIT = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at all-ones so a disabled watchdog can never wrap back to LIMIT.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (waiting && !mem_resp && (cnt_q != '1))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // A response on the limit cycle wins over the abort.
   assign timeout = (MEM_TIMEOUT != 0) && waiting && !mem_resp && (cnt_q == LIMIT);

endmodule

// File: rtl/lc3b_control_fsm.sv
// Multicycle control unit for the LC-3b datapath.
// Inputs : clk, rst_n (sync, active-low), opcode (IR[15:12]), br_en,
//          ir_imm (IR[5]), ir_bit4 (IR[4], SHF right-shift select),
//          ir_jsr (IR[11]), mar_lsb (MAR[0]), mem_resp
// Outputs: pcmux_sel, marmux_sel, alumux_sel, regfilemux_sel, alu_op,
//          load_pc/ir/mar/mdr/regfile/cc, mdrmux_sel, storemux_sel,
//          destmux_sel, mem_read, mem_write, mem_byte_enable,
//          mem_timeout (watchdog abort pulse), illegal_op (decode pulse)
//
// state      | meaning
// fetch1     | MAR<-PC, PC<-PC+2
// fetch2     | read instruction into MDR (wait)
// fetch3     | IR<-MDR
// decode     | dispatch on opcode, flag illegal opcodes
// s_add/and  | DR<-ALU, CC update
// s_not/shf  | DR<-ALU, CC update
// br         | test NZP
// br_taken   | PC<-PC+off9
// s_jmp      | PC<-sr1
// jsr_link   | R7<-PC
// jsr_jump   | PC<-PC+off9 (JSR) or sr1 (JSRR)
// s_lea      | DR<-PC+off9, CC update
// calc_addr  | MAR<-base+off6
// ind_rd     | read pointer word (wait)
// ind_mar    | MAR<-MDR
// ld_rd      | read data (wait)
// ldr_wb     | DR<-MDR, CC update
// ldb_wb     | DR<-ZEXT(byte), CC update
// str_mdr    | MDR<-SR
// st_wr      | write (wait)
// trap_link  | R7<-PC
// trap_mar   | MAR<-ZEXT(trapvect8)<<1
// trap_rd    | read vector (wait)
// trap_pc    | PC<-MDR
module lc3b_control_fsm
   import lc3b_control_fsm_pkg::*;
#(
   parameter int MEM_TIMEOUT     = 0,
   parameter bit ENABLE_INDIRECT = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] opcode,
   input  logic       br_en,
   input  logic       ir_imm,
   input  logic       ir_bit4,
   input  logic       ir_jsr,
   input  logic       mar_lsb,
   input  logic       mem_resp,
   output logic [1:0] pcmux_sel,
   output logic [1:0] marmux_sel,
   output logic [1:0] alumux_sel,
   output logic [2:0] regfilemux_sel,
   output logic [2:0] alu_op,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_mar,
   output logic       load_mdr,
   output logic       load_regfile,
   output logic       load_cc,
   output logic       mdrmux_sel,
   output logic       storemux_sel,
   output logic       destmux_sel,
   output logic       mem_read,
   output logic       mem_write,
   output logic [1:0] mem_byte_enable,
   output logic       mem_timeout,
   output logic       illegal_op
);

   logic [4:0] state_q, state_d;
   lc3b_opcode op;
   logic       op_illegal;
   logic       wd_clear, wd_waiting, wd_timeout;

   assign op = lc3b_opcode'(opcode);
   assign op_illegal = (op == op_rti) ||
                       (!ENABLE_INDIRECT && ((op == op_ldi) || (op == op_sti)));

   assign wd_waiting = is_wait_state(state_q);
   assign wd_clear   = is_wait_state(state_d) && (state_d != state_q);

   lc3b_mem_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (wd_clear),
      .waiting  (wd_waiting),
      .mem_resp (mem_resp),
      .timeout  (wd_timeout)
   );

   assign mem_timeout = rst_n & wd_timeout;

   always_ff @(posedge clk) begin
      if (!rst_n)
         state_q <= ST_FETCH1;
      else
         state_q <= state_d;
   end

   // Outputs stay at their defaults while rst_n is low.
   always_comb begin
      state_d         = state_q;
      pcmux_sel       = pcmux_pc_plus2;
      marmux_sel      = marmux_alu;
      alumux_sel      = alumux_sr2;
      regfilemux_sel  = rfmux_alu;
      alu_op          = alu_add;
      load_pc         = 1'b0;
      load_ir         = 1'b0;
      load_mar        = 1'b0;
      load_mdr        = 1'b0;
      load_regfile    = 1'b0;
      load_cc         = 1'b0;
      mdrmux_sel      = 1'b0;
      storemux_sel    = 1'b0;
      destmux_sel     = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 2'b11;
      illegal_op      = 1'b0;

      if (rst_n) begin
         case (state_q)
            ST_FETCH1: begin
               marmux_sel = marmux_pc;
               load_mar   = 1'b1;
               load_pc    = 1'b1;
               state_d    = ST_FETCH2;
            end
            ST_FETCH2: begin
               mem_read   = 1'b1;
               mdrmux_sel = 1'b1;
               load_mdr   = 1'b1;
               if (mem_resp)        state_d = ST_FETCH3;
               else if (wd_timeout) state_d = ST_FETCH1;
            end
            ST_FETCH3: begin
               load_ir = 1'b1;
               state_d = ST_DECODE;
            end
            ST_DECODE: begin
               if (op_illegal) begin
                  illegal_op = 1'b1;
                  state_d    = ST_FETCH1;
               end else begin
                  case (op)
                     op_add:  state_d = ST_ADD;
                     op_and:  state_d = ST_AND;
                     op_not:  state_d = ST_NOT;
                     op_shf:  state_d = ST_SHF;
                     op_br:   state_d = ST_BR;
                     op_jmp:  state_d = ST_JMP;
                     op_jsr:  state_d = ST_JSR_LINK;
                     op_lea:  state_d = ST_LEA;
                     op_trap: state_d = ST_TRAP_LINK;
                     op_ldr, op_ldb, op_str, op_stb, op_ldi, op_sti:
                              state_d = ST_CALC_ADDR;
                     default: state_d = ST_FETCH1;
                  endcase
               end
            end
            ST_ADD, ST_AND: begin
               alu_op       = (state_q == ST_ADD) ? alu_add : alu_and;
               alumux_sel   = ir_imm ? alumux_imm5 : alumux_sr2;
               load_regfile = 1'b1;
               load_cc      = 1'b1;
               state_d      = ST_FETCH1;
            end
            ST_NOT: begin
               alu_op       = alu_not;
               load_regfile = 1'b1;
               load_cc      = 1'b1;
               state_d      = ST_FETCH1;
            end
            ST_SHF: begin
               // IR[4]=0 left shift; IR[5] picks arithmetic vs logical right shift.
               alumux_sel   = alumux_imm4;
               alu_op       = !ir_bit4 ? alu_sll : (ir_imm ? alu_sra : alu_srl);
               load_regfile = 1'b1;
               load_cc      = 1'b1;
               state_d      = ST_FETCH1;
            end
            ST_BR: begin
               state_d = br_en ? ST_BR_TAKEN : ST_FETCH1;
            end
            ST_BR_TAKEN: begin
               pcmux_sel = pcmux_pc_off9;
               load_pc   = 1'b1;
               state_d   = ST_FETCH1;
            end
            ST_JMP: begin
               pcmux_sel = pcmux_sr1;
               load_pc   = 1'b1;
               state_d   = ST_FETCH1;
            end
            ST_JSR_LINK, ST_TRAP_LINK: begin
               destmux_sel    = 1'b1;
               regfilemux_sel = rfmux_pc;
               load_regfile   = 1'b1;
               state_d        = (state_q == ST_JSR_LINK) ? ST_JSR_JUMP : ST_TRAP_MAR;
            end
            ST_JSR_JUMP: begin
               pcmux_sel = ir_jsr ? pcmux_pc_off9 : pcmux_sr1;
               load_pc   = 1'b1;
               state_d   = ST_FETCH1;
            end
            ST_LEA: begin
               regfilemux_sel = rfmux_pc_off9;
               load_regfile   = 1'b1;
               load_cc        = 1'b1;
               state_d        = ST_FETCH1;
            end
            ST_CALC_ADDR: begin
               alumux_sel = alumux_off6;
               marmux_sel = marmux_alu;
               load_mar   = 1'b1;
               if ((op == op_ldi) || (op == op_sti))      state_d = ST_IND_RD;
               else if ((op == op_ldr) || (op == op_ldb)) state_d = ST_LD_RD;
               else                                       state_d = ST_STR_MDR;
            end
            ST_IND_RD: begin
               mem_read   = 1'b1;
               mdrmux_sel = 1'b1;
               load_mdr   = 1'b1;
               if (mem_resp)        state_d = ST_IND_MAR;
               else if (wd_timeout) state_d = ST_FETCH1;
            end
            ST_IND_MAR: begin
               marmux_sel = marmux_mdr;
               load_mar   = 1'b1;
               state_d    = (op == op_ldi) ? ST_LD_RD : ST_STR_MDR;
            end
            ST_LD_RD: begin
               mem_read   = 1'b1;
               mdrmux_sel = 1'b1;
               load_mdr   = 1'b1;
               if (mem_resp)        state_d = (op == op_ldb) ? ST_LDB_WB : ST_LDR_WB;
               else if (wd_timeout) state_d = ST_FETCH1;
            end
            ST_LDR_WB, ST_LDB_WB: begin
               regfilemux_sel = (state_q == ST_LDB_WB) ? rfmux_mdr_byte : rfmux_mdr;
               load_regfile   = 1'b1;
               load_cc        = 1'b1;
               state_d        = ST_FETCH1;
            end
            ST_STR_MDR: begin
               storemux_sel = 1'b1;
               alu_op       = alu_pass;
               load_mdr     = 1'b1;
               state_d      = ST_ST_WR;
            end
            ST_ST_WR: begin
               mem_write = 1'b1;
               if (op == op_stb)
                  mem_byte_enable = mar_lsb ? 2'b10 : 2'b01;
               if (mem_resp)        state_d = ST_FETCH1;
               else if (wd_timeout) state_d = ST_FETCH1;
            end
            ST_TRAP_MAR: begin
               marmux_sel = marmux_trapvect;
               load_mar   = 1'b1;
               state_d    = ST_TRAP_RD;
            end
            ST_TRAP_RD: begin
               mem_read   = 1'b1;
               mdrmux_sel = 1'b1;
               load_mdr   = 1'b1;
               if (mem_resp)        state_d = ST_TRAP_PC;
               else if (wd_timeout) state_d = ST_FETCH1;
            end
            ST_TRAP_PC: begin
               pcmux_sel = pcmux_mdr;
               load_pc   = 1'b1;
               state_d   = ST_FETCH1;
            end
            default: state_d = ST_FETCH1;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3b_control_fsm.sv
module tb_lc3b_control_fsm;

   typedef struct packed {
      logic [1:0] pcmux;
      logic [1:0] marmux;
      logic [1:0] alumux;
      logic [2:0] rfmux;
      logic [2:0] alu_op;
      logic       load_pc;
      logic       load_ir;
      logic       load_mar;
      logic       load_mdr;
      logic       load_rf;
      logic       load_cc;
      logic       mdrmux;
      logic       storemux;
      logic       destmux;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] be;
      logic       timeout;
      logic       illegal;
   } outs_t;

   typedef struct {
      logic [3:0] op;
      logic       imm, b4, jsr, br, lsb, use_b;
      int         n;
      outs_t      exp [0:8];
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] opcode = 4'b0;
   logic       br_en = 1'b0, ir_imm = 1'b0, ir_bit4 = 1'b0, ir_jsr = 1'b0;
   logic       mar_lsb = 1'b0, mem_resp = 1'b0;

   logic [1:0] a_pcmux, a_marmux, a_alumux, a_be, b_pcmux, b_marmux, b_alumux, b_be;
   logic [2:0] a_rfmux, a_aluop, b_rfmux, b_aluop;
   logic a_ld_pc, a_ld_ir, a_ld_mar, a_ld_mdr, a_ld_rf, a_ld_cc, a_mdrmux, a_storemux, a_destmux;
   logic a_rd, a_wr, a_to, a_ill;
   logic b_ld_pc, b_ld_ir, b_ld_mar, b_ld_mdr, b_ld_rf, b_ld_cc, b_mdrmux, b_storemux, b_destmux;
   logic b_rd, b_wr, b_to, b_ill;
   outs_t act_a, act_b;

   always #5 clk = ~clk;

   // dut_a: watchdog limit 4, indirect enabled; dut_b: watchdog off, indirect disabled
   lc3b_control_fsm #(.MEM_TIMEOUT(4), .ENABLE_INDIRECT(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_en(br_en), .ir_imm(ir_imm),
      .ir_bit4(ir_bit4), .ir_jsr(ir_jsr), .mar_lsb(mar_lsb), .mem_resp(mem_resp),
      .pcmux_sel(a_pcmux), .marmux_sel(a_marmux), .alumux_sel(a_alumux),
      .regfilemux_sel(a_rfmux), .alu_op(a_aluop), .load_pc(a_ld_pc), .load_ir(a_ld_ir),
      .load_mar(a_ld_mar), .load_mdr(a_ld_mdr), .load_regfile(a_ld_rf), .load_cc(a_ld_cc),
      .mdrmux_sel(a_mdrmux), .storemux_sel(a_storemux), .destmux_sel(a_destmux),
      .mem_read(a_rd), .mem_write(a_wr), .mem_byte_enable(a_be),
      .mem_timeout(a_to), .illegal_op(a_ill));

   lc3b_control_fsm #(.MEM_TIMEOUT(0), .ENABLE_INDIRECT(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_en(br_en), .ir_imm(ir_imm),
      .ir_bit4(ir_bit4), .ir_jsr(ir_jsr), .mar_lsb(mar_lsb), .mem_resp(mem_resp),
      .pcmux_sel(b_pcmux), .marmux_sel(b_marmux), .alumux_sel(b_alumux),
      .regfilemux_sel(b_rfmux), .alu_op(b_aluop), .load_pc(b_ld_pc), .load_ir(b_ld_ir),
      .load_mar(b_ld_mar), .load_mdr(b_ld_mdr), .load_regfile(b_ld_rf), .load_cc(b_ld_cc),
      .mdrmux_sel(b_mdrmux), .storemux_sel(b_storemux), .destmux_sel(b_destmux),
      .mem_read(b_rd), .mem_write(b_wr), .mem_byte_enable(b_be),
      .mem_timeout(b_to), .illegal_op(b_ill));

   assign act_a = {a_pcmux, a_marmux, a_alumux, a_rfmux, a_aluop, a_ld_pc, a_ld_ir, a_ld_mar,
                   a_ld_mdr, a_ld_rf, a_ld_cc, a_mdrmux, a_storemux, a_destmux, a_rd, a_wr,
                   a_be, a_to, a_ill};
   assign act_b = {b_pcmux, b_marmux, b_alumux, b_rfmux, b_aluop, b_ld_pc, b_ld_ir, b_ld_mar,
                   b_ld_mdr, b_ld_rf, b_ld_cc, b_mdrmux, b_storemux, b_destmux, b_rd, b_wr,
                   b_be, b_to, b_ill};

   int    n_checks = 0;
   int    n_err = 0;
   logic  cur_b = 1'b0;
   vec_t  vecs [0:31];
   int    nvec = 0;

   outs_t E_DEF, E_F1, E_F2, E_F2TO, E_F3, E_DEC, E_ADD_R, E_ADD_I, E_AND_I, E_NOT;
   outs_t E_SLL, E_SRL, E_SRA, E_BRT, E_JMP, E_LINK, E_LEA, E_CALC, E_LDRWB, E_LDBWB;
   outs_t E_STMDR, E_STW11, E_STW10, E_STW01, E_INDMAR, E_TMAR, E_TPC;

   function automatic outs_t dflt();
      outs_t o;
      o = '0;
      o.be = 2'b11;
      return o;
   endfunction

   task automatic check(input outs_t exp, input string name);
      outs_t act;
      @(negedge clk);
      act = cur_b ? act_b : act_a;
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      mem_resp = 1'b0;
      step();
      check(E_DEF, "reset_outputs");
      step();
      rst_n = 1'b1;
   endtask

   task automatic add_vec(input logic [3:0] op, input logic imm, input logic b4,
                          input logic jsr, input logic br, input logic lsb,
                          input logic use_b, input logic ill, input int n,
                          input outs_t s4, input outs_t s5, input outs_t s6,
                          input outs_t s7, input outs_t s8);
      vec_t v;
      v.op = op; v.imm = imm; v.b4 = b4; v.jsr = jsr; v.br = br; v.lsb = lsb;
      v.use_b = use_b; v.n = n;
      v.exp[0] = E_F1; v.exp[1] = E_F2; v.exp[2] = E_F3; v.exp[3] = E_DEC;
      v.exp[3].illegal = ill;
      v.exp[4] = s4; v.exp[5] = s5; v.exp[6] = s6; v.exp[7] = s7; v.exp[8] = s8;
      vecs[nvec] = v;
      nvec++;
   endtask

   initial begin
      #100000;
      $display("FAIL global_time_limit: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      E_DEF  = dflt();
      E_F1   = dflt(); E_F1.marmux = 2'd1; E_F1.load_mar = 1'b1; E_F1.load_pc = 1'b1;
      E_F2   = dflt(); E_F2.mem_read = 1'b1; E_F2.mdrmux = 1'b1; E_F2.load_mdr = 1'b1;
      E_F2TO = E_F2;   E_F2TO.timeout = 1'b1;
      E_F3   = dflt(); E_F3.load_ir = 1'b1;
      E_DEC  = dflt();
      E_ADD_R = dflt(); E_ADD_R.load_rf = 1'b1; E_ADD_R.load_cc = 1'b1;
      E_ADD_I = E_ADD_R; E_ADD_I.alumux = 2'd2;
      E_AND_I = E_ADD_I; E_AND_I.alu_op = 3'd1;
      E_NOT   = E_ADD_R; E_NOT.alu_op = 3'd2;
      E_SLL   = E_ADD_R; E_SLL.alumux = 2'd3; E_SLL.alu_op = 3'd4;
      E_SRL   = E_SLL;   E_SRL.alu_op = 3'd5;
      E_SRA   = E_SLL;   E_SRA.alu_op = 3'd6;
      E_BRT   = dflt();  E_BRT.pcmux = 2'd1; E_BRT.load_pc = 1'b1;
      E_JMP   = dflt();  E_JMP.pcmux = 2'd2; E_JMP.load_pc = 1'b1;
      E_LINK  = dflt();  E_LINK.destmux = 1'b1; E_LINK.rfmux = 3'd3; E_LINK.load_rf = 1'b1;
      E_LEA   = E_ADD_R; E_LEA.rfmux = 3'd2;
      E_CALC  = dflt();  E_CALC.alumux = 2'd1; E_CALC.load_mar = 1'b1;
      E_LDRWB = E_ADD_R; E_LDRWB.rfmux = 3'd1;
      E_LDBWB = E_ADD_R; E_LDBWB.rfmux = 3'd4;
      E_STMDR = dflt();  E_STMDR.storemux = 1'b1; E_STMDR.alu_op = 3'd3; E_STMDR.load_mdr = 1'b1;
      E_STW11 = dflt();  E_STW11.mem_write = 1'b1;
      E_STW10 = E_STW11; E_STW10.be = 2'b10;
      E_STW01 = E_STW11; E_STW01.be = 2'b01;
      E_INDMAR = dflt(); E_INDMAR.marmux = 2'd2; E_INDMAR.load_mar = 1'b1;
      E_TMAR  = dflt();  E_TMAR.marmux = 2'd3; E_TMAR.load_mar = 1'b1;
      E_TPC   = dflt();  E_TPC.pcmux = 2'd3; E_TPC.load_pc = 1'b1;

      //      op      imm  b4   jsr  br   lsb  b    ill  n
      add_vec(4'b0001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_ADD_R, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b0001,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_ADD_I, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b0101,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_AND_I, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b1001,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_NOT, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b1101,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_SLL, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b1101,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_SRL, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b1101,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_SRA, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_DEF, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,6, E_DEF, E_BRT, E_DEF, E_DEF, E_DEF);
      add_vec(4'b1100,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_JMP, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b0100,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,6, E_LINK, E_BRT, E_DEF, E_DEF, E_DEF);
      add_vec(4'b0100,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,6, E_LINK, E_JMP, E_DEF, E_DEF, E_DEF);
      add_vec(4'b1110,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,5, E_LEA, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b0110,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,7, E_CALC, E_F2, E_LDRWB, E_DEF, E_DEF);
      add_vec(4'b0010,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,7, E_CALC, E_F2, E_LDBWB, E_DEF, E_DEF);
      add_vec(4'b0111,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,7, E_CALC, E_STMDR, E_STW11, E_DEF, E_DEF);
      add_vec(4'b0011,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,7, E_CALC, E_STMDR, E_STW10, E_DEF, E_DEF);
      add_vec(4'b0011,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,7, E_CALC, E_STMDR, E_STW01, E_DEF, E_DEF);
      add_vec(4'b1010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9, E_CALC, E_F2, E_INDMAR, E_F2, E_LDRWB);
      add_vec(4'b1011,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,9, E_CALC, E_F2, E_INDMAR, E_STMDR, E_STW11);
      add_vec(4'b1111,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8, E_LINK, E_TMAR, E_F2, E_TPC, E_DEF);
      add_vec(4'b1000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4, E_DEF, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b1010,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4, E_DEF, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b1011,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4, E_DEF, E_DEF, E_DEF, E_DEF, E_DEF);
      add_vec(4'b0110,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,7, E_CALC, E_F2, E_LDRWB, E_DEF, E_DEF);

      cur_b = 1'b0;
      do_reset();
      for (int i = 0; i < nvec; i++) begin
         if (vecs[i].use_b != cur_b) begin
            cur_b = vecs[i].use_b;
            do_reset();
         end
         opcode = vecs[i].op; ir_imm = vecs[i].imm; ir_bit4 = vecs[i].b4;
         ir_jsr = vecs[i].jsr; br_en = vecs[i].br; mar_lsb = vecs[i].lsb;
         mem_resp = 1'b1;
         for (int c = 0; c < vecs[i].n; c++) begin
            check(vecs[i].exp[c], $sformatf("vec%0d_cyc%0d", i, c));
            step();
         end
      end
      check(E_F1, "table_end_fetch1");

      // Reset asserted for two cycles while parked in ld_rd.
      cur_b = 1'b1;
      do_reset();
      opcode = 4'b0110; ir_imm = 1'b0; ir_bit4 = 1'b0; br_en = 1'b0; mem_resp = 1'b1;
      for (int c = 0; c < 5; c++) step();
      mem_resp = 1'b0;
      check(E_F2, "ldrd_wait_1");
      step();
      check(E_F2, "ldrd_wait_2");
      step();
      rst_n = 1'b0;
      check(E_DEF, "reset_mid_ldrd_1");
      step();
      check(E_DEF, "reset_mid_ldrd_2");
      step();
      rst_n = 1'b1;
      check(E_F1, "post_reset_fetch1");

      // Watchdog disabled: long fetch wait never aborts.
      do_reset();
      opcode = 4'b0001; ir_imm = 1'b1; mem_resp = 1'b0;
      check(E_F1, "nowd_fetch1");
      step();
      for (int k = 0; k < 10; k++) begin
         check(E_F2, $sformatf("nowd_wait%0d", k));
         step();
      end
      mem_resp = 1'b1;
      check(E_F2, "nowd_resp");
      step();
      check(E_F3, "nowd_fetch3");

      // ADD R1,R2,#-3 with response on the 4th wait cycle (the limit cycle).
      cur_b = 1'b0;
      do_reset();
      opcode = 4'b0001; ir_imm = 1'b1; mem_resp = 1'b0;
      check(E_F1, "waitadd_fetch1");
      step();
      for (int k = 0; k < 4; k++) begin
         if (k == 3) mem_resp = 1'b1;
         check(E_F2, $sformatf("waitadd_fetch2_%0d", k));
         step();
      end
      check(E_F3, "waitadd_fetch3");
      step();
      check(E_DEC, "waitadd_decode");
      step();
      check(E_ADD_I, "waitadd_s_add");
      step();
      check(E_F1, "waitadd_back_fetch1");

      // No response at all: abort on the 4th wait cycle.
      mem_resp = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         check(E_F2, $sformatf("to_wait%0d", k));
         step();
      end
      check(E_F2TO, "to_pulse");
      step();
      check(E_F1, "to_abandon_fetch1");
      step();
      check(E_F2, "to_refetch_counter_cleared");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
